// File: rtl/aes_iter_core_pkg.sv
// Shared types and GF(2^8) arithmetic for the iterative AES core.
package aes_pkg;

    // 16 bytes; byte i (i = r + 4c) lives at element 15-i so that byte 0 is bits [127:120].
    typedef logic [15:0][7:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEY0,
        ST_ROUND,
        ST_DONE
    } fsm_e;

    localparam logic [7:0] INV_EXP = 8'hfe;  // x^254 == x^-1 in GF(2^8)

    function automatic int nr_of(input int key_bits);
        case (key_bits)
            128:     return 10;
            192:     return 12;
            256:     return 14;
            default: return 0;
        endcase
    endfunction

    // Element index of state byte s[r][c].
    function automatic logic [3:0] bidx(input int r, input int c);
        return 4'(15 - (r + 4 * c));
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse by square-and-multiply; 0 maps to 0 naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (INV_EXP[i]) r = gf_mul(r, x);
        end
        return r;
    endfunction

    // S-box derived arithmetically (inverse followed by the affine map) rather than tabulated.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    // One output byte of MixColumns given the column rotated so a0 is the same row.
    function automatic logic [7:0] mix_row(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3);
        return xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    endfunction

    function automatic logic [7:0] inv_mix_row(input logic [7:0] a0, input logic [7:0] a1,
                                               input logic [7:0] a2, input logic [7:0] a3);
        return gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// Block stream interface: input block handshake and result handshake.
interface aes_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_decrypt;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_decrypt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_decrypt, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_iter_core_round.sv
// Purely combinational single AES round, encrypt or straightforward inverse.
module aes_round_core
    import aes_pkg::*;
(
    input  aes_state_t state,
    input  aes_state_t round_key,
    input  logic       decrypt,
    input  logic       final_round,
    output aes_state_t next_state
);

    aes_state_t sb, sr, mc, enc_s;
    aes_state_t isr, isb, ark, imc, dec_s;

    // Both directions are built in parallel and the requested one is selected.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sb = '0; sr = '0; mc = '0; isr = '0; isb = '0; ark = '0; imc = '0;

        // Encrypt: SubBytes, ShiftRows, MixColumns (skipped on the final round), AddRoundKey.
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sb[bidx(r, c)] = sbox(state[bidx(r, c)]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[bidx(r, c)] = sb[bidx(r, (c + r) % 4)];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                mc[bidx(r, c)] = mix_row(sr[bidx(r, c)], sr[bidx((r + 1) % 4, c)],
                                         sr[bidx((r + 2) % 4, c)], sr[bidx((r + 3) % 4, c)]);
        enc_s = (final_round ? sr : mc) ^ round_key;

        // Decrypt: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (skipped on the final round).
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                isr[bidx(r, (c + r) % 4)] = state[bidx(r, c)];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                isb[bidx(r, c)] = inv_sbox(isr[bidx(r, c)]);
        ark = isb ^ round_key;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                imc[bidx(r, c)] = inv_mix_row(ark[bidx(r, c)], ark[bidx((r + 1) % 4, c)],
                                              ark[bidx((r + 2) % 4, c)], ark[bidx((r + 3) % 4, c)]);
        dec_s = final_round ? ark : imc;

        next_state = decrypt ? dec_s : enc_s;
    end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 engine: one round per clock, keys from an external registered RAM.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 256
) (
    input  logic            clk,
    input  logic            rst,
    aes_iter_core_if.slave  bus,
    output logic [3:0]      rk_addr,
    input  logic [127:0]    rk_data,
    output logic            busy
);

    localparam logic [3:0] NR = 4'(nr_of(KEY_BITS));

    if (nr_of(KEY_BITS) == 0) begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
    end

    fsm_e       fsm_q, fsm_d;
    aes_state_t state_q, state_d;
    aes_state_t out_q, out_d;
    aes_state_t round_out;
    logic       dec_q, dec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] rk_addr_q, rk_addr_d;
    logic       accept;
    logic       last_round;
    logic [3:0] rk_step;

    assign accept     = bus.in_valid && (fsm_q == ST_IDLE);
    assign last_round = (cnt_q == NR);
    assign rk_step    = dec_q ? (rk_addr_q - 4'd1) : (rk_addr_q + 4'd1);

    aes_round_core u_round (
        .state       (state_q),
        .round_key   (rk_data),
        .decrypt     (dec_q),
        .final_round (last_round),
        .next_state  (round_out)
    );

    // State register: FSM, datapath and key address, synchronously reset.
    always_ff @(posedge clk) begin
        // NOTE: the state and result registers are reset too, so out_data reads 0 and no stale block leaks.
        if (rst) begin
            fsm_q     <= ST_IDLE;
            state_q   <= '0;
            out_q     <= '0;
            dec_q     <= 1'b0;
            cnt_q     <= 4'd0;
            rk_addr_q <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            out_q     <= out_d;
            dec_q     <= dec_d;
            cnt_q     <= cnt_d;
            rk_addr_q <= rk_addr_d;
        end
    end

    // Next-state logic for the block sequencer.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE:  if (accept)        fsm_d = ST_KEY0;
            ST_KEY0:                     fsm_d = ST_ROUND;
            ST_ROUND: if (last_round)    fsm_d = ST_DONE;
            ST_DONE:  if (bus.out_ready) fsm_d = ST_IDLE;
            default:                     fsm_d = ST_IDLE;
        endcase
    end

    // Datapath and key-address sequencing; the address is issued one cycle ahead of its use.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        dec_d     = dec_q;
        cnt_d     = cnt_q;
        rk_addr_d = rk_addr_q;
        case (fsm_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = bus.in_data;
                    dec_d     = bus.in_decrypt;
                    rk_addr_d = bus.in_decrypt ? NR : 4'd0;
                end
            end
            ST_KEY0: begin
                state_d   = state_q ^ rk_data;
                cnt_d     = 4'd1;
                rk_addr_d = rk_step;
            end
            ST_ROUND: begin
                state_d = round_out;
                cnt_d   = cnt_q + 4'd1;
                // The final round's key is already addressed; hold so the index stays in 0..NR.
                if (last_round) out_d = round_out;
                else            rk_addr_d = rk_step;
            end
            default: ;
        endcase
    end

    // Output logic: handshake flags decoded from the registered state only.
    always_comb begin
        bus.in_ready  = (fsm_q == ST_IDLE);
        bus.out_valid = (fsm_q == ST_DONE);
        busy          = (fsm_q != ST_IDLE);
    end

    assign bus.out_data = out_q;
    assign rk_addr      = rk_addr_d;

endmodule
